// File: rtl/lcd_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | lcd_pkg                                                                |
// | Shared types, opcodes and init ROM for the HD44780-style LCD sequencer.|
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SETUP = 3'd2,
    ST_PULSE = 3'd3,
    ST_HOLD  = 3'd4,
    ST_EXEC  = 3'd5
  } lcd_state_e;

  localparam logic [7:0] LCD_FUNC_8BIT = 8'h38;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_CLR       = 8'h01;
  localparam logic [7:0] LCD_HOME      = 8'h02;
  localparam logic [7:0] LCD_ENTRY_INC = 8'h06;

  localparam int INIT_LEN = 6;

  // Entry 0 is the leftmost element, so the list reads in issue order.
  localparam logic [0:INIT_LEN-1][7:0] INIT_ROM = {
    LCD_FUNC_8BIT, LCD_FUNC_8BIT, LCD_FUNC_8BIT,
    LCD_DISP_ON, LCD_CLR, LCD_ENTRY_INC
  };

  function automatic int unsigned at_least_one(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Clear (0x01) and home (0x02/0x03, bit 0 is don't-care) need the long wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == LCD_CLR) || (data[7:1] == LCD_HOME[7:1]));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_delay_cnt.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | lcd_delay_cnt                                                          |
// | Loadable down-counter; done is high in the last cycle of a load.       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module lcd_delay_cnt #(
  parameter int              CNT_W   = 20,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter parks at zero when idle so done is a single-cycle pulse.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/lcd_timing_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | lcd_timing_seq                                                         |
// | Power-up init and write-strobe timing for an 8-bit character LCD.     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module lcd_timing_seq
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_AS    = 2,
  parameter int unsigned T_PW    = 12,
  parameter int unsigned T_H     = 2,
  parameter int unsigned T_EXEC  = 2000,
  parameter int unsigned T_CLR   = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       init_done,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_data_out,
  output logic       LCD_data_oe
);

  localparam int unsigned PWRUP_N = at_least_one(T_PWRUP);
  localparam int unsigned AS_N    = at_least_one(T_AS);
  localparam int unsigned PW_N    = at_least_one(T_PW);
  localparam int unsigned H_N     = at_least_one(T_H);
  localparam int unsigned EXEC_N  = at_least_one(T_EXEC);
  localparam int unsigned CLR_N   = at_least_one(T_CLR);
  localparam int unsigned MAX_N   = max_u(max_u(max_u(PWRUP_N, AS_N), max_u(PW_N, H_N)),
                                          max_u(EXEC_N, CLR_N));
  localparam int          CNT_W   = $clog2(MAX_N + 1);

  localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(PWRUP_N);
  localparam logic [CNT_W-1:0] LD_AS    = CNT_W'(AS_N);
  localparam logic [CNT_W-1:0] LD_PW    = CNT_W'(PW_N);
  localparam logic [CNT_W-1:0] LD_H     = CNT_W'(H_N);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(EXEC_N);
  localparam logic [CNT_W-1:0] LD_CLR   = CNT_W'(CLR_N);

  localparam int              IDX_W    = $clog2(INIT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INIT_LEN - 1);

  lcd_state_e       state_q, state_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] idx_next;
  logic             init_done_q, init_done_d;

  logic             cnt_start;
  logic [CNT_W-1:0] cnt_load;
  logic             cnt_done;

  lcd_delay_cnt #(
    .CNT_W   (CNT_W),
    .RST_VAL (LD_PWRUP)
  ) u_delay (
    .clk      (clk),
    .reset    (reset),
    .start    (cnt_start),
    .load_val (cnt_load),
    .done     (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_PWRUP;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      idx_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
    end
  end

  // Every transition that leaves a state also reloads the counter for the next one.
  always_comb begin
    state_d     = state_q;
    rs_d        = rs_q;
    data_d      = data_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    idx_next    = idx_q + IDX_W'(1);
    cnt_start   = 1'b0;
    cnt_load    = LD_AS;
    case (state_q)
      ST_PWRUP: begin
        if (cnt_done) begin
          idx_d     = '0;
          rs_d      = 1'b0;
          data_d    = INIT_ROM[0];
          state_d   = ST_SETUP;
          cnt_start = 1'b1;
          cnt_load  = LD_AS;
        end
      end
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          rs_d      = cmd_rs;
          data_d    = cmd_data;
          state_d   = ST_SETUP;
          cnt_start = 1'b1;
          cnt_load  = LD_AS;
        end
      end
      ST_SETUP: begin
        if (cnt_done) begin
          state_d   = ST_PULSE;
          cnt_start = 1'b1;
          cnt_load  = LD_PW;
        end
      end
      ST_PULSE: begin
        if (cnt_done) begin
          state_d   = ST_HOLD;
          cnt_start = 1'b1;
          cnt_load  = LD_H;
        end
      end
      ST_HOLD: begin
        if (cnt_done) begin
          state_d   = ST_EXEC;
          cnt_start = 1'b1;
          cnt_load  = is_slow_cmd(rs_q, data_q) ? LD_CLR : LD_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_done) begin
          if (init_done_q) begin
            state_d = ST_IDLE;
          end else if (idx_q == LAST_IDX) begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            idx_d     = idx_next;
            rs_d      = 1'b0;
            data_d    = INIT_ROM[idx_next];
            state_d   = ST_SETUP;
            cnt_start = 1'b1;
            cnt_load  = LD_AS;
          end
        end
      end
      default: begin
        state_d = ST_PWRUP;
      end
    endcase
  end

  always_comb begin
    LCD_E        = (state_q == ST_PULSE);
    LCD_RS       = rs_q;
    LCD_data_out = data_q;
    LCD_RW       = 1'b0;
    LCD_data_oe  = (state_q != ST_PWRUP);
    cmd_ready    = (state_q == ST_IDLE) && init_done_q;
    init_done    = init_done_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_lcd_timing_seq                                                      |
// | Self-checking bench: interval-based reference model plus vector table. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_lcd_timing_seq;

  localparam int P_PWRUP = 10;
  localparam int P_AS    = 1;
  localparam int P_PW    = 3;
  localparam int P_H     = 1;
  localparam int P_EXEC  = 5;
  localparam int P_CLR   = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_rs = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, init_done, LCD_E, LCD_RS, LCD_RW, LCD_data_oe;
  logic [7:0] LCD_data_out;

  lcd_timing_seq #(
    .T_PWRUP (P_PWRUP), .T_AS (P_AS), .T_PW (P_PW),
    .T_H (P_H), .T_EXEC (P_EXEC), .T_CLR (P_CLR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_rs       (cmd_rs),
    .cmd_data     (cmd_data),
    .init_done    (init_done),
    .LCD_E        (LCD_E),
    .LCD_RS       (LCD_RS),
    .LCD_RW       (LCD_RW),
    .LCD_data_out (LCD_data_out),
    .LCD_data_oe  (LCD_data_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         exp_high;
    int         exp_busy;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: each transfer is an interval starting at edge m_s of length m_len.
  int         n;
  int         m_s, m_len, m_idx;
  logic       m_rs;
  logic [7:0] m_data;
  logic       ready_prev, e_prev;
  logic [7:0] pulse_q[$];
  int         done_at;
  logic [7:0] exp_rom [0:5] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b at cycle %0d", name, act, exp, n);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h at cycle %0d", name, act, exp, n);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, n);
    end
  endtask

  function automatic int seg_len(input logic rs, input logic [7:0] d);
    int x;
    x = (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? P_CLR : P_EXEC;
    return P_AS + P_PW + P_H + x;
  endfunction

  function automatic logic [7:0] pick_data();
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 3));
    return 8'($urandom);
  endfunction

  task automatic model_reset();
    n          = 0;
    m_idx      = 0;
    m_s        = P_PWRUP;
    m_rs       = 1'b0;
    m_data     = exp_rom[0];
    m_len      = seg_len(1'b0, exp_rom[0]);
    ready_prev = 1'b0;
    e_prev     = 1'b0;
    done_at    = -1;
    pulse_q.delete();
  endtask

  task automatic step(input logic v, input logic rs, input logic [7:0] d);
    logic acc;
    logic busy;
    int   o;
    @(negedge clk);
    reset     = 1'b0;
    cmd_valid = v;
    cmd_rs    = rs;
    cmd_data  = d;
    acc       = v && ready_prev;
    @(posedge clk);
    #1;
    n++;
    if (acc) begin
      m_s = n; m_rs = rs; m_data = d; m_len = seg_len(rs, d);
    end else if (m_idx < 6 && n == m_s + m_len) begin
      if (m_idx == 5) begin
        m_idx = 6;
      end else begin
        m_idx++;
        m_s = n; m_rs = 1'b0; m_data = exp_rom[m_idx]; m_len = seg_len(1'b0, m_data);
      end
    end
    o    = n - m_s;
    busy = (n < m_s + m_len);
    chk1("lcd_e", LCD_E, (o >= P_AS) && (o < P_AS + P_PW));
    chk1("init_done", init_done, m_idx == 6);
    chk1("cmd_ready", cmd_ready, (m_idx == 6) && !busy);
    chk1("data_oe", LCD_data_oe, n >= P_PWRUP);
    chk1("lcd_rw", LCD_RW, 1'b0);
    if (n < P_PWRUP) begin
      chk1("pwrup_rs", LCD_RS, 1'b0);
      chk8("pwrup_data", LCD_data_out, 8'h00);
    end else if (busy) begin
      chk1("xfer_rs", LCD_RS, m_rs);
      chk8("xfer_data", LCD_data_out, m_data);
    end
    if (LCD_E && !e_prev) pulse_q.push_back(LCD_data_out);
    if (init_done && done_at < 0) done_at = n;
    e_prev     = LCD_E;
    ready_prev = (m_idx == 6) && !busy;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset     = 1'b1;
    cmd_valid = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      chk1("rst_lcd_e", LCD_E, 1'b0);
      chk1("rst_lcd_rs", LCD_RS, 1'b0);
      chk1("rst_lcd_rw", LCD_RW, 1'b0);
      chk8("rst_data", LCD_data_out, 8'h00);
      chk1("rst_oe", LCD_data_oe, 1'b0);
      chk1("rst_ready", cmd_ready, 1'b0);
      chk1("rst_init_done", init_done, 1'b0);
    end
    model_reset();
  endtask

  // Random requests during init must be ignored; the model never accepts them.
  task automatic run_init(input logic rand_valid);
    for (int i = 0; i < 200 && done_at < 0; i++) begin
      step(rand_valid ? 1'($urandom) : 1'b0, 1'($urandom), pick_data());
    end
    chki("init_cycles", done_at, P_PWRUP + 6 * (P_AS + P_PW + P_H) + 5 * P_EXEC + P_CLR);
    chki("init_pulse_count", pulse_q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < pulse_q.size()) chk8($sformatf("init_pulse%0d", i), pulse_q[i], exp_rom[i]);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 60 && !cmd_ready; i++) step(1'b0, 1'b0, 8'h00);
    chk1("ready_wait", cmd_ready, 1'b1);
  endtask

  task automatic send_one(input vec_t v, input int idx);
    int         acc_n, e_cnt, busy;
    logic       prs;
    logic [7:0] pd;
    wait_ready();
    step(1'b1, v.rs, v.data);
    acc_n = n;
    e_cnt = 0;
    busy  = -1;
    prs   = 1'bx;
    pd    = 8'hxx;
    for (int i = 0; i < 60 && busy < 0; i++) begin
      step(1'b0, 1'($urandom), 8'($urandom));
      if (LCD_E) begin
        e_cnt++;
        prs = LCD_RS;
        pd  = LCD_data_out;
      end
      if (cmd_ready) busy = n - acc_n;
    end
    chki($sformatf("vec%0d_e_high", idx), e_cnt, v.exp_high);
    chki($sformatf("vec%0d_busy", idx), busy, v.exp_busy);
    chk1($sformatf("vec%0d_rs", idx), prs, v.rs);
    chk8($sformatf("vec%0d_data", idx), pd, v.data);
  endtask

  initial begin
    vec_t vecs[8];
    int   guard;
    vecs[0] = '{1'b1, 8'h41, 3, 10};
    vecs[1] = '{1'b0, 8'h01, 3, 25};
    vecs[2] = '{1'b0, 8'h80, 3, 10};
    vecs[3] = '{1'b0, 8'h02, 3, 25};
    vecs[4] = '{1'b0, 8'h03, 3, 25};
    vecs[5] = '{1'b0, 8'h04, 3, 10};
    vecs[6] = '{1'b1, 8'h01, 3, 10};
    vecs[7] = '{1'b0, 8'h00, 3, 10};

    do_reset(3);
    run_init(1'b1);

    for (int i = 0; i < 8; i++) send_one(vecs[i], i);

    // Requester holds valid continuously while the byte changes every cycle.
    for (int i = 0; i < 300; i++) step(1'b1, 1'($urandom), pick_data());

    for (int i = 0; i < 400; i++) step($urandom_range(0, 2) == 0, 1'($urandom), pick_data());

    // Reset landing in the second cycle of an enable pulse.
    wait_ready();
    step(1'b1, 1'b1, 8'h55);
    guard = 0;
    while (!LCD_E && guard < 20) begin
      step(1'b0, 1'b0, 8'h00);
      guard++;
    end
    chk1("mid_pulse_first", LCD_E, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    chk1("mid_pulse_second", LCD_E, 1'b1);
    do_reset(1);
    run_init(1'b1);

    for (int i = 0; i < 200; i++) step($urandom_range(0, 1) == 0, 1'($urandom), pick_data());

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lcd_timing_seq.md
LCD_TIMING_SEQ -- requirements
Module: lcd_timing_seq

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter T_PWRUP, 750000: clk cycles of power-up wait after reset (15 ms at 50 MHz).
REQ-002 The block SHALL have parameter T_AS, 2: cycles from RS/data valid to LCD_E rise.
REQ-003 The block SHALL have parameter T_PW, 12: cycles LCD_E is high.
REQ-004 The block SHALL have parameter T_H, 2: cycles RS/data are held after LCD_E falls.
REQ-005 The block SHALL have parameter T_EXEC, 2000: post-transfer wait for normal commands and data (40 us).
REQ-006 The block SHALL have parameter T_CLR, 82000: post-transfer wait for clear and home commands (1.64 ms).

Ports (name, direction, width, meaning):
REQ-007 The block SHALL have port clk, input, 1: sole clock.
REQ-008 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-009 The block SHALL have port cmd_valid, input, 1: requester offers a transfer.
REQ-010 The block SHALL have port cmd_ready, output, 1: block accepts a transfer this cycle.
REQ-011 The block SHALL have port cmd_rs, input, 1: 0 = instruction, 1 = data.
REQ-012 The block SHALL have port cmd_data, input, 8: byte to write.
REQ-013 The block SHALL have port init_done, output, 1: power-up sequence complete.
REQ-014 The block SHALL have port LCD_E, output, 1: enable strobe.
REQ-015 The block SHALL have port LCD_RS, output, 1: register select.
REQ-016 The block SHALL have port LCD_RW, output, 1: constant 0 (write-only).
REQ-017 The block SHALL have port LCD_data_out, output, 8: byte driven to the panel.
REQ-018 The block SHALL have port LCD_data_oe, output, 1: pad output enable; 1 whenever not in PWRUP.

Function
REQ-019 The FSM SHALL have states PWRUP, IDLE, SETUP, PULSE, HOLD and EXEC, with one down-counter sized for the largest parameter.
REQ-020 PWRUP SHALL wait T_PWRUP cycles, then load init ROM entry 0 and enter SETUP.
REQ-021 The init ROM SHALL hold, in order with rs=0: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
REQ-022 cmd_ready SHALL be 1 only in IDLE with init_done=1; it is combinational from state only and never depends on cmd_valid.
REQ-023 On cmd_valid & cmd_ready, the block SHALL latch cmd_rs and cmd_data and enter SETUP on the next cycle; a single-cycle handshake accepts exactly one transfer.
REQ-024 SETUP SHALL drive LCD_RS and LCD_data_out from the latch with LCD_E=0 for exactly T_AS cycles.
REQ-025 PULSE SHALL hold LCD_E=1 for exactly T_PW cycles.
REQ-026 HOLD SHALL hold LCD_E=0 with RS and data unchanged for exactly T_H cycles.
REQ-027 EXEC SHALL wait T_CLR cycles if rs=0 and data is 0x01, 0x02 or 0x03; otherwise it waits T_EXEC cycles.
REQ-028 When EXEC expires during init, the block SHALL load the next ROM entry and enter SETUP; after entry 5, it sets init_done=1 and enters IDLE.
REQ-029 When EXEC expires after a requester transfer, the block SHALL enter IDLE.
REQ-030 cmd_valid asserted outside IDLE, or before init_done, SHALL be ignored with no side effects.
REQ-031 The latched RS and data SHALL NOT change between SETUP entry and EXEC exit, whatever the inputs do.
REQ-032 A parameter value of 0 SHALL be treated as 1, so every state lasts at least one cycle.
REQ-033 Back-to-back transfers SHALL occur at 1 + T_AS + T_PW + T_H + T_EXEC cycles minimum.

Reset
REQ-034 While reset=1 at a clk edge, the block SHALL enter PWRUP with counter = T_PWRUP, ROM index 0 and init_done=0.
REQ-035 During reset, outputs SHALL be LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_data_out=0x00, LCD_data_oe=0 and cmd_ready=0.
REQ-036 Reset asserted in any state, including mid-PULSE, SHALL drop LCD_E on the next edge and restart the full init sequence.

Structure
REQ-037 A shared package lcd_pkg SHALL hold the state enum, the init ROM constants, and the LCD_CLR, LCD_HOME and LCD_FUNC_8BIT opcodes.
REQ-038 The six init bytes SHALL be a constant array in lcd_pkg, not literals inside the FSM.
REQ-039 One sub-module, lcd_delay_cnt (load value, start, done pulse), SHALL be instantiated once.

Verification
All scenarios SHALL use T_PWRUP=10, T_AS=1, T_PW=3, T_H=1, T_EXEC=5, T_CLR=20.
REQ-040 Release reset: init_done rises after exactly 10 + 6 x (1+3+1) + 5 x 5 + 20 cycles; the bench checks the 6 E pulses carry 38, 38, 38, 0C, 01, 06.
REQ-041 After init, send cmd_rs=1 with data 0x41: E is high for exactly 3 cycles with RS=1 and data=41, and cmd_ready returns 1 after 10 cycles.
REQ-042 Send cmd_rs=0 with data 0x01: the EXEC wait is 20 cycles; then 0x80: the EXEC wait is 5 cycles.
REQ-043 Hold cmd_valid high continuously with changing data: each byte is accepted only while cmd_ready=1, and the latched byte is stable throughout its pulse.
REQ-044 Assert reset in the 2nd PULSE cycle: LCD_E=0 next cycle, init_done=0, and the full init sequence repeats.
REQ-045 Assert cmd_valid before init_done: the request causes no E pulse and no latch change.
